// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: default width, FSM states and
// the bit-counter width helper.
package byte_serializer_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shift register with a bit counter; exposes the
// current and the upcoming MSB / last-bit status so the top can register outputs.
module piso_shifter
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             msb,
  output logic             next_msb,
  output logic             last_bit,
  output logic             next_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // Counter restarts at every load, so it never wraps within a word
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt + CW'(1);
    end
  end

  assign msb       = shreg[WIDTH-1];
  assign next_msb  = shreg[WIDTH-2];
  assign last_bit  = (cnt == LAST_IDX);
  assign next_last = (cnt == PRE_LAST_IDX);

endmodule

// File: rtl/byte_serializer.sv
// Valid/ready word input, MSB-first serial output with a one-entry holding
// register so consecutive words stream without an idle cycle.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             shift_enable,
  output logic             byte_done,
  output logic             busy
);

  state_t           state, state_next;
  logic             hold_full, hold_set, hold_clr, hold_next;
  logic [WIDTH-1:0] hold_word, load_data;
  logic             handshake, load, shift;
  logic             msb, next_msb, last_bit, next_last;
  logic             so_next, se_next, bd_next, busy_next;

  assign data_ready = !rst && !hold_full;
  assign handshake  = data_valid && data_ready;

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .shift     (shift),
    .msb       (msb),
    .next_msb  (next_msb),
    .last_bit  (last_bit),
    .next_last (next_last)
  );

  // Next state, word routing, and the values the output registers take next
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = data_in;
    shift      = 1'b0;
    hold_set   = 1'b0;
    hold_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (hold_full) begin
            load      = 1'b1;
            load_data = hold_word;
            hold_clr  = 1'b1;
          end else if (handshake) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          shift    = 1'b1;
          hold_set = handshake;
        end
      end
      default: state_next = IDLE;
    endcase

    se_next   = (state_next == SHIFT);
    so_next   = se_next && (load ? load_data[WIDTH-1] : next_msb);
    bd_next   = se_next && !load && next_last;
    hold_next = (hold_full && !hold_clr) || hold_set;
    busy_next = se_next || hold_next;
  end

  // State, holding register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_full    <= 1'b0;
      hold_word    <= '0;
      serial_out   <= 1'b0;
      shift_enable <= 1'b0;
      byte_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      hold_full    <= hold_next;
      if (hold_set) hold_word <= data_in;
      serial_out   <= so_next;
      shift_enable <= se_next;
      byte_done    <= bd_next;
      busy         <= busy_next;
    end
  end

endmodule

// File: doc/byte_serializer.md
# byte_serializer

Parallel-to-serial converter that drives the serial side of the byte streamer. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, with a qualifying `shift_enable` strobe. Its `serial_out` and `shift_enable` wire straight into the receiver's `serial_in` and `shift_enable`. A one-entry holding register allows back-to-back words with no idle cycle between them.

## Interface
- `WIDTH`, 8: word width in bits; must be at least 2.
- `clk`  input  1: single clock; all logic on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `data_in`  input  WIDTH: parallel word, sampled on handshake.
- `data_valid`  input  1: source has a word on `data_in`.
- `data_ready`  output  1: block can accept a word; equals `!rst && !hold_full`.
- `serial_out`  output  1: current serial bit, MSB first; 0 when not shifting.
- `shift_enable`  output  1: high in every cycle `serial_out` carries a valid bit.
- `byte_done`  output  1: one-cycle pulse, coincident with the last bit of each word.
- `busy`  output  1: high while shifting or while the holding register is full.

## Operation
- Handshake: a word is accepted on a rising edge where `data_valid && data_ready`. `data_in` may change freely after acceptance.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word; bit counter runs from 0 to WIDTH-1.
- Accepted word, routing:
  - Goes directly into the shifter if the state is IDLE, or if the state is SHIFT in its last-bit cycle with the holding register empty.
  - Otherwise goes into the holding register, which sets `hold_full`.
- Last-bit cycle, counter == WIDTH-1:
  - Holding register full: its word loads into the shifter and `hold_full` clears.
  - Else, a handshake in this cycle: the new word loads into the shifter.
  - Else: go to IDLE.
- Each SHIFT cycle: `serial_out` = shifter MSB, `shift_enable` = 1. At the edge, the shifter shifts left and the counter increments.
- Both `hold_full` and a handshake in the same cycle cannot occur, because `data_ready` is low whenever `hold_full` is set.
- All outputs except `data_ready` are registered.
- The counter is `$clog2(WIDTH)` bits wide and resets to 0 at every word load, so there is no wrap-around hazard.

## Timing
- Reset values: `serial_out`=0, `shift_enable`=0, `byte_done`=0, `busy`=0. `data_ready`=0 while `rst` is high and 1 in the first cycle after.
- Reset mid-word: the in-flight word and any held word are discarded. No partial `byte_done` is produced.
- Latency: handshake at edge E (state IDLE) → first bit with `shift_enable`=1 in the cycle after E. Bits occupy WIDTH consecutive cycles, and `byte_done` is high in the WIDTH-th cycle.
- Throughput:
  - Continuous streaming gives one bit per clock, with `shift_enable` never dropping between words.
  - A second word may be accepted one cycle after the first. `data_ready` then stays low until the first word's last-bit edge.
- Receiver pairing: on the edge ending a `byte_done` cycle, the receiver's `parallel_out` equals the transmitted word.

## Structure
- Shared package holds:
  - the `WIDTH` default constant;
  - the state enum {IDLE, SHIFT};
  - the counter-width localparam function (`$clog2`).
- One natural sub-module: `piso_shifter`. It holds the shift register and bit counter, with load/shift inputs and `last_bit`/`msb` outputs.
- Top level keeps the FSM, the holding register and the handshake logic.

## Test plan
- Reset: assert `rst` for 3 cycles while `data_valid`=1 → all outputs 0 and no word accepted; `data_ready`=1 in the first cycle after release.
- Single word 8'hA5 from IDLE → `serial_out` reads 1,0,1,0,0,1,0,1 over 8 cycles with `shift_enable`=1; `byte_done` high in cycle 8 only; the paired receiver reads 8'hA5.
- Back-to-back 8'h3C then 8'hC3 with `data_valid` held high → 16 contiguous `shift_enable` cycles; `data_ready` low from cycle 2 to the last-bit cycle of word 1; two `byte_done` pulses, 8 cycles apart.
- Handshake exactly in the last-bit cycle with the holding register empty (8'hFF then 8'h01) → no gap; the second word starts the next cycle and `hold_full` never sets.
- Reset mid-word: pulse `rst` after 3 bits of 8'h81 with 8'h7E held → outputs go to 0 the next cycle, no `byte_done`, and neither word resumes afterwards.
- Parameter sweep with `WIDTH`=16, word 16'h8001 → 16 bits, MSB first; `byte_done` in cycle 16.
